// File: rtl/dut_seq_pkg.sv
// Shared types and widths for the vector sequencer.
package dut_seq_pkg;

   localparam int unsigned VEC_W    = 20;
   localparam int unsigned RES_W    = 10;
   localparam int unsigned SETTLE_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_APPLY,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

endpackage

// File: rtl/dut_seq_settle_timer.sv
// Settle-time down counter: loaded with SETTLE_CYCLES, decremented while settling.
module dut_seq_settle_timer
   import dut_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   logic [SETTLE_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= SETTLE_W'(SETTLE_CYCLES);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Flags the decrement that brings the count to zero, so the dwell is exactly SETTLE_CYCLES.
   assign o_zero = (r_cnt == SETTLE_W'(1));

endmodule

// File: rtl/dut_vector_sequencer.sv
// Applies stored vectors to reference/optimized netlists, logs ref results, flags mismatches.
// Optional mismatch statistics ports enabled by defining DUT_SEQ_MISMATCH_LOG_EN.
module dut_vector_sequencer
   import dut_seq_pkg::*;
#(
   parameter int unsigned ADDR_W        = 8,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_vecs,
   output logic              vec_re,
   output logic [ADDR_W-1:0] vec_addr,
   input  logic [VEC_W-1:0]  vec_data,
   output logic [VEC_W-1:0]  dut_in,
   input  logic [RES_W-1:0]  ref_out,
   input  logic [RES_W-1:0]  opt_out,
   output logic              res_we,
   output logic [ADDR_W-1:0] res_addr,
   output logic [RES_W-1:0]  res_data,
   output logic              busy,
   output logic              done,
`ifdef DUT_SEQ_MISMATCH_LOG_EN
   output logic              pass,
   output logic [ADDR_W:0]   mismatch_cnt,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic              first_fail_valid
`else
   output logic              pass
`endif
);

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W:0]     r_num;
   logic [VEC_W-1:0]    r_dut_in;
   logic                r_pass;

   logic                w_accept;
   logic                w_active;
   logic                w_abort;
   logic                w_capture;
   logic                w_last_vec;
   logic                w_mismatch;
   logic                w_settle_zero;

   dut_seq_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_load  (r_state == S_APPLY),
      .i_dec   (r_state == S_SETTLE),
      .o_zero  (w_settle_zero)
   );

   // DONE is already terminating, so abort only redirects the working states.
   assign w_active   = (r_state == S_FETCH) || (r_state == S_APPLY) ||
                       (r_state == S_SETTLE) || (r_state == S_CAPTURE);
   assign w_abort    = abort && w_active;
   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_capture  = (r_state == S_CAPTURE) && !abort;
   assign w_last_vec = ({1'b0, r_idx} == (r_num - 1'b1));
   assign w_mismatch = (ref_out != opt_out);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (start) w_next = (num_vecs == '0) ? S_DONE : S_FETCH;
         S_FETCH:   w_next = S_APPLY;
         S_APPLY:   w_next = S_SETTLE;
         S_SETTLE:  if (w_settle_zero) w_next = S_CAPTURE;
         S_CAPTURE: w_next = w_last_vec ? S_DONE : S_FETCH;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_num    <= '0;
         r_dut_in <= '0;
         r_pass   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_idx  <= '0;
            r_num  <= num_vecs;
            r_pass <= 1'b1;
         end
         if ((r_state == S_APPLY) && !abort) r_dut_in <= vec_data;
         if (w_capture && w_mismatch) r_pass <= 1'b0;
         if (w_capture && !w_last_vec) r_idx <= r_idx + 1'b1;
         if (w_abort) r_pass <= 1'b0;
      end
   end

`ifdef DUT_SEQ_MISMATCH_LOG_EN
   logic [ADDR_W:0]   r_mm_cnt;
   logic [ADDR_W-1:0] r_ff_addr;
   logic              r_ff_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mm_cnt   <= '0;
         r_ff_addr  <= '0;
         r_ff_valid <= 1'b0;
      end else if (w_accept) begin
         r_mm_cnt   <= '0;
         r_ff_addr  <= '0;
         r_ff_valid <= 1'b0;
      end else if (w_capture && w_mismatch) begin
         if (r_mm_cnt != '1) r_mm_cnt <= r_mm_cnt + 1'b1;
         if (!r_ff_valid) begin
            r_ff_addr  <= r_idx;
            r_ff_valid <= 1'b1;
         end
      end
   end

   assign mismatch_cnt     = r_mm_cnt;
   assign first_fail_addr  = r_ff_addr;
   assign first_fail_valid = r_ff_valid;
`endif

   assign vec_re   = (r_state == S_FETCH);
   assign vec_addr = r_idx;
   assign dut_in   = r_dut_in;
   assign res_we   = w_capture;
   assign res_addr = r_idx;
   assign res_data = ref_out;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign pass     = r_pass;

endmodule
